// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared definitions for the instruction-decode stage: opcode
//                encodings, instruction field bit positions, run/halt state
//                encoding, control-bit bundle and small decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    // Opcode encodings (instr[15:12])
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_ADDI = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_JMP  = 4'd11;
    localparam logic [3:0] OP_MFHI = 4'd12;
    localparam logic [3:0] OP_MFLO = 4'd13;
    localparam logic [3:0] OP_NOP  = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    // Instruction field bit positions
    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 12;
    localparam int RD_MSB    = 11;
    localparam int RD_LSB    = 9;
    localparam int RS_MSB    = 8;
    localparam int RS_LSB    = 6;
    localparam int RT_MSB    = 5;
    localparam int RT_LSB    = 3;
    localparam int SHAMT_MSB = 2;
    localparam int CONST_MSB = 5;
    localparam int ADDR_MSB  = 7;

    // Run/halt state encoding
    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [3:0] op);
        ctrl_t c;
        c.reg_write = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL,
                                 OP_LW, OP_ADDI, OP_MFHI, OP_MFLO};
        c.mem_read  = (op == OP_LW);
        c.mem_write = (op == OP_SW);
        return c;
    endfunction

    // SW and BEQ compare/store the rd register, so port B reads rd for them.
    function automatic logic port_b_is_rd(input logic [3:0] op);
        return (op == OP_SW) || (op == OP_BEQ);
    endfunction

    // Whether rs is a genuine source operand (for hazard purposes).
    function automatic logic uses_rs(input logic [3:0] op);
        return !(op inside {OP_JMP, OP_NOP, OP_HALT, OP_MFHI, OP_MFLO});
    endfunction

    // Whether the port-B register is a genuine source operand.
    function automatic logic uses_port_b(input logic [3:0] op);
        return (op <= OP_MUL) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_if
//  Description : Bundle of the decode stage's fetch-side, writeback-side and
//                ID/EX-side signals.
//                slave  : decode stage view (fetch/wb inputs, ID/EX outputs)
//                master : environment view (drives fetch/wb, observes ID/EX)
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    // Fetch side
    logic          if_valid;
    logic [15:0]   if_instr;
    logic [7:0]    if_pc;
    logic          flush;
    logic          stall;
    // Writeback side
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    // ID/EX pipeline register
    logic          ex_valid;
    logic [3:0]    opcode;
    logic [2:0]    shamt;
    logic [5:0]    constant;
    logic [7:0]    address;
    logic [7:0]    pc;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [AW-1:0] rd_addr;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          halted;

    modport slave (
        input  if_valid, if_instr, if_pc, flush, wb_we, wb_addr, wb_data,
        output stall, ex_valid, opcode, shamt, constant, address, pc,
               rs_data, rt_data, rd_addr, reg_write, mem_read, mem_write, halted
    );

    modport master (
        output if_valid, if_instr, if_pc, flush, wb_we, wb_addr, wb_data,
        input  stall, ex_valid, opcode, shamt, constant, address, pc,
               rs_data, rt_data, rd_addr, reg_write, mem_read, mem_write, halted
    );

endinterface
`default_nettype wire

// File: rtl/decode_stage_regfile8x16.sv
`default_nettype none
// ============================================================================
//  Module      : regfile8x16
//  Description : Register file, two combinational read ports, one synchronous
//                write port, synchronous clear. r0 always reads zero and
//                ignores writes.
//                Optional macro DECODE_WB_BYPASS_EN: a same-cycle write to a
//                register being read is forwarded to that read port.
//  Ports       : clk, rst            - clock, synchronous active-high clear
//                we/waddr/wdata      - write port
//                raddr_a/rdata_a     - read port A
//                raddr_b/rdata_b     - read port B
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile8x16 #(
    parameter int NREGS = 8,
    parameter int DW    = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [DW-1:0] wdata,
    input  wire logic [AW-1:0] raddr_a,
    output logic      [DW-1:0] rdata_a,
    input  wire logic [AW-1:0] raddr_b,
    output logic      [DW-1:0] rdata_b
);

    logic [DW-1:0] r_regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            r_regs[waddr] <= wdata;
        end
    end

`ifdef DECODE_WB_BYPASS_EN
    logic w_byp_a;
    logic w_byp_b;

    assign w_byp_a = we && (waddr != '0) && (waddr == raddr_a);
    assign w_byp_b = we && (waddr != '0) && (waddr == raddr_b);

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (raddr_a != '0) rdata_a = w_byp_a ? wdata : r_regs[raddr_a];
        if (raddr_b != '0) rdata_b = w_byp_b ? wdata : r_regs[raddr_b];
    end
`else
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (raddr_a != '0) rdata_a = r_regs[raddr_a];
        if (raddr_b != '0) rdata_b = r_regs[raddr_b];
    end
`endif

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Instruction-decode stage. Splits the fetched instruction into
//                fields, reads operands from the register file, detects
//                load-use hazards (stalling fetch and issuing a bubble) and
//                registers the result into the ID/EX pipeline register. A
//                run/halt FSM stops issue after a HALT.
//                Optional macro DECODE_WB_BYPASS_EN enables writeback
//                write-through inside the register file.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - decode_stage_if.slave (fetch, writeback, ID/EX)
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int DW    = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    decode_stage_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    // Decode of the instruction currently in IF/ID
    logic [3:0]    w_op;
    logic [AW-1:0] w_rd;
    logic [AW-1:0] w_rs;
    logic [AW-1:0] w_rt;
    logic [AW-1:0] w_port_b;
    ctrl_t         w_ctrl;
    logic [DW-1:0] w_rs_data;
    logic [DW-1:0] w_rt_data;
    logic          w_hazard;
    logic          w_halted;
    logic          w_load;

    // ID/EX register and FSM
    logic          r_ex_valid;
    logic [3:0]    r_opcode;
    logic [2:0]    r_shamt;
    logic [5:0]    r_constant;
    logic [7:0]    r_address;
    logic [7:0]    r_pc;
    logic [DW-1:0] r_rs_data;
    logic [DW-1:0] r_rt_data;
    logic [AW-1:0] r_rd_addr;
    ctrl_t         r_ctrl;
    state_e        r_state;

    assign w_op     = bus.if_instr[OPC_MSB:OPC_LSB];
    assign w_rd     = bus.if_instr[RD_MSB:RD_LSB];
    assign w_rs     = bus.if_instr[RS_MSB:RS_LSB];
    assign w_rt     = bus.if_instr[RT_MSB:RT_LSB];
    assign w_port_b = port_b_is_rd(w_op) ? w_rd : w_rt;
    assign w_ctrl   = decode_ctrl(w_op);
    assign w_halted = (r_state == ST_HALTED);

    regfile8x16 #(
        .NREGS (NREGS),
        .DW    (DW),
        .AW    (AW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.wb_we),
        .waddr   (bus.wb_addr),
        .wdata   (bus.wb_data),
        .raddr_a (w_rs),
        .rdata_a (w_rs_data),
        .raddr_b (w_port_b),
        .rdata_b (w_rt_data)
    );

    // A load in EX produces its value too late for the instruction in decode;
    // a load to r0 never produces anything, so it cannot cause a hazard.
    assign w_hazard = r_ex_valid && r_ctrl.mem_read && (r_rd_addr != '0) &&
                      bus.if_valid &&
                      ((uses_rs(w_op)     && (w_rs     == r_rd_addr)) ||
                       (uses_port_b(w_op) && (w_port_b == r_rd_addr)));

    // Flush and halt both discard the decode instruction, so holding fetch
    // would be pointless.
    assign bus.stall = w_hazard && !bus.flush && !w_halted;

    assign w_load = bus.if_valid && !bus.flush && !w_halted && !w_hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_opcode   <= '0;
            r_shamt    <= '0;
            r_constant <= '0;
            r_address  <= '0;
            r_pc       <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_rd_addr  <= '0;
            r_ctrl     <= '0;
            r_state    <= ST_RUN;
        end else begin
            if (w_load) begin
                r_ex_valid <= 1'b1;
                r_opcode   <= w_op;
                r_shamt    <= bus.if_instr[SHAMT_MSB:0];
                r_constant <= bus.if_instr[CONST_MSB:0];
                r_address  <= bus.if_instr[ADDR_MSB:0];
                r_pc       <= bus.if_pc;
                r_rs_data  <= w_rs_data;
                r_rt_data  <= w_rt_data;
                r_rd_addr  <= w_rd;
                r_ctrl     <= w_ctrl;
            end else begin
                r_ex_valid <= 1'b0;
                r_opcode   <= '0;
                r_shamt    <= '0;
                r_constant <= '0;
                r_address  <= '0;
                r_pc       <= '0;
                r_rs_data  <= '0;
                r_rt_data  <= '0;
                r_rd_addr  <= '0;
                r_ctrl     <= '0;
            end
            // HALTED is left only through reset.
            if (w_load && (w_op == OP_HALT)) begin
                r_state <= ST_HALTED;
            end
        end
    end

    assign bus.ex_valid  = r_ex_valid;
    assign bus.opcode    = r_opcode;
    assign bus.shamt     = r_shamt;
    assign bus.constant  = r_constant;
    assign bus.address   = r_address;
    assign bus.pc        = r_pc;
    assign bus.rs_data   = r_rs_data;
    assign bus.rt_data   = r_rt_data;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.reg_write = r_ctrl.reg_write;
    assign bus.mem_read  = r_ctrl.mem_read;
    assign bus.mem_write = r_ctrl.mem_write;
    assign bus.halted    = w_halted;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Directed self-checking bench for decode_stage. Each step
//                drives one cycle of fetch/writeback inputs, checks the
//                combinational stall, and compares the ID/EX outputs after the
//                edge against an expectation queued when the step was driven.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    typedef struct packed {
        logic        ex_valid;
        logic [3:0]  opcode;
        logic [2:0]  shamt;
        logic [5:0]  constant;
        logic [7:0]  address;
        logic [7:0]  pc;
        logic [15:0] rs_data;
        logic [15:0] rt_data;
        logic [2:0]  rd_addr;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        halted;
    } obs_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    obs_t exp_q [$];
    logic [15:0] ref_regs [8];

    decode_stage_if bus ();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.ex_valid  = bus.ex_valid;
        o.opcode    = bus.opcode;
        o.shamt     = bus.shamt;
        o.constant  = bus.constant;
        o.address   = bus.address;
        o.pc        = bus.pc;
        o.rs_data   = bus.rs_data;
        o.rt_data   = bus.rt_data;
        o.rd_addr   = bus.rd_addr;
        o.reg_write = bus.reg_write;
        o.mem_read  = bus.mem_read;
        o.mem_write = bus.mem_write;
        o.halted    = bus.halted;
        return o;
    endfunction

    function automatic obs_t bubble(input logic h);
        obs_t o;
        o        = '0;
        o.halted = h;
        return o;
    endfunction

    // Expected ID/EX contents for an instruction that issues normally,
    // using the bench's own copy of the register file.
    function automatic obs_t issued(input logic [15:0] ins, input logic [7:0] p,
                                    input logic h);
        obs_t       o;
        logic [3:0] op;
        logic [2:0] rbsel;
        op          = ins[15:12];
        rbsel       = (op == 4'd8 || op == 4'd10) ? ins[11:9] : ins[5:3];
        o.ex_valid  = 1'b1;
        o.opcode    = op;
        o.shamt     = ins[2:0];
        o.constant  = ins[5:0];
        o.address   = ins[7:0];
        o.pc        = p;
        o.rs_data   = ref_regs[ins[8:6]];
        o.rt_data   = ref_regs[rbsel];
        o.rd_addr   = ins[11:9];
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd9, 4'd12, 4'd13:
                o.reg_write = 1'b1;
            default:
                o.reg_write = 1'b0;
        endcase
        o.mem_read  = (op == 4'd7);
        o.mem_write = (op == 4'd8);
        o.halted    = h;
        return o;
    endfunction

    task automatic step(input string tag, input logic r, input logic v,
                        input logic [15:0] ins, input logic [7:0] p,
                        input logic fl, input logic we, input logic [2:0] wa,
                        input logic [15:0] wd, input logic exp_stall,
                        input obs_t e);
        obs_t got;
        obs_t want;
        rst         = r;
        bus.if_valid = v;
        bus.if_instr = ins;
        bus.if_pc    = p;
        bus.flush    = fl;
        bus.wb_we    = we;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
        exp_q.push_back(e);
        #1;
        checks++;
        assert (bus.stall === exp_stall) else begin
            errors++;
            $error("FAIL %s stall: got %b expected %b", tag, bus.stall, exp_stall);
        end
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0000;
        end else if (we && wa != 3'd0) begin
            ref_regs[wa] = wd;
        end
        got  = sample();
        want = exp_q.pop_front();
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s idex: got %h expected %h", tag, got, want);
        end
    endtask

    initial begin
        obs_t e;
        obs_t got;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0000;

        rst          = 1'b1;
        bus.if_valid = 1'b0;
        bus.if_instr = 16'h0000;
        bus.if_pc    = 8'h00;
        bus.flush    = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_addr  = 3'd0;
        bus.wb_data  = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        got = sample();
        checks++;
        assert (got === bubble(1'b0)) else begin
            errors++;
            $error("FAIL reset idex: got %h expected %h", got, bubble(1'b0));
        end

        // Fill registers through the writeback port while fetch is idle.
        step("wb_r1", 0, 0, 16'h0000, 8'h00, 0, 1, 3'd1, 16'h0005, 0, bubble(0));
        step("wb_r2", 0, 0, 16'h0000, 8'h00, 0, 1, 3'd2, 16'h0003, 0, bubble(0));
        step("wb_r4", 0, 0, 16'h0000, 8'h00, 0, 1, 3'd4, 16'h1234, 0, bubble(0));
        step("wb_r5", 0, 0, 16'h0000, 8'h00, 0, 1, 3'd5, 16'h1111, 0, bubble(0));
        step("wb_r0", 0, 0, 16'h0000, 8'h00, 0, 1, 3'd0, 16'hFFFF, 0, bubble(0));

        // ADD r3,r1,r2
        step("add", 0, 1, 16'h0650, 8'h10, 0, 0, 3'd0, 16'h0, 0, issued(16'h0650, 8'h10, 0));
        // LW r1 then dependent ADD: one stall cycle, one bubble, then issue
        step("lw", 0, 1, 16'h7280, 8'h11, 0, 0, 3'd0, 16'h0, 0, issued(16'h7280, 8'h11, 0));
        step("lu_stall", 0, 1, 16'h0650, 8'h12, 0, 0, 3'd0, 16'h0, 1, bubble(0));
        step("lu_issue", 0, 1, 16'h0650, 8'h12, 0, 0, 3'd0, 16'h0, 0, issued(16'h0650, 8'h12, 0));
        // JMP whose rs field names the load target: not a real source
        step("lw2", 0, 1, 16'h7280, 8'h13, 0, 0, 3'd0, 16'h0, 0, issued(16'h7280, 8'h13, 0));
        step("jmp", 0, 1, 16'hB041, 8'h14, 0, 0, 3'd0, 16'h0, 0, issued(16'hB041, 8'h14, 0));
        // Load to r0 never causes a hazard
        step("lw_r0", 0, 1, 16'h7080, 8'h15, 0, 0, 3'd0, 16'h0, 0, issued(16'h7080, 8'h15, 0));
        step("add_r0", 0, 1, 16'h0600, 8'h16, 0, 0, 3'd0, 16'h0, 0, issued(16'h0600, 8'h16, 0));
        // SW r4,r1,#2: port B reads rd
        e = issued(16'h8842, 8'h17, 0);
        step("sw", 0, 1, 16'h8842, 8'h17, 0, 0, 3'd0, 16'h0, 0, e);
        checks++;
        assert (bus.rt_data === 16'h1234 && bus.mem_write === 1'b1 &&
                bus.constant === 6'd2 && bus.reg_write === 1'b0) else begin
            errors++;
            $error("FAIL sw_fields: got rt=%h mw=%b c=%h rw=%b expected 1234/1/02/0",
                   bus.rt_data, bus.mem_write, bus.constant, bus.reg_write);
        end
        // Flush in the hazard cycle: no stall, bubble
        step("lw3", 0, 1, 16'h7280, 8'h18, 0, 0, 3'd0, 16'h0, 0, issued(16'h7280, 8'h18, 0));
        step("flush", 0, 1, 16'h0650, 8'h19, 1, 0, 3'd0, 16'h0, 0, bubble(0));
        step("after_fl", 0, 1, 16'h0650, 8'h1A, 0, 0, 3'd0, 16'h0, 0, issued(16'h0650, 8'h1A, 0));
        // Hazard through port B (SW reading rd=r1)
        step("lw4", 0, 1, 16'h7280, 8'h1B, 0, 0, 3'd0, 16'h0, 0, issued(16'h7280, 8'h1B, 0));
        step("sw_stall", 0, 1, 16'h8200, 8'h1C, 0, 0, 3'd0, 16'h0, 1, bubble(0));
        step("sw_issue", 0, 1, 16'h8200, 8'h1C, 0, 0, 3'd0, 16'h0, 0, issued(16'h8200, 8'h1C, 0));

        // OR r6,r5,r0 decoded while r5 is written in the same cycle
        e = issued(16'h3D40, 8'h1D, 0);
`ifdef DECODE_WB_BYPASS_EN
        e.rs_data = 16'hABCD;
`else
        e.rs_data = 16'h1111;
`endif
        step("wb_same", 0, 1, 16'h3D40, 8'h1D, 0, 1, 3'd5, 16'hABCD, 0, e);
        step("wb_after", 0, 1, 16'h3D40, 8'h1E, 0, 0, 3'd0, 16'h0, 0, issued(16'h3D40, 8'h1E, 0));

        // HALT issues once, then bubbles regardless of input
        step("halt", 0, 1, 16'hF000, 8'h20, 0, 0, 3'd0, 16'h0, 0, issued(16'hF000, 8'h20, 1));
        step("halted1", 0, 1, 16'h0650, 8'h21, 0, 0, 3'd0, 16'h0, 0, bubble(1));
        step("halted2", 0, 1, 16'h7280, 8'h22, 0, 0, 3'd0, 16'h0, 0, bubble(1));

        // Reset out of HALTED with a valid instruction present; clears registers
        step("rst_halt", 1, 1, 16'h0650, 8'h23, 0, 0, 3'd0, 16'h0, 0, bubble(0));
        step("post_rst", 0, 1, 16'h0650, 8'h24, 0, 0, 3'd0, 16'h0, 0, issued(16'h0650, 8'h24, 0));
        checks++;
        assert (bus.rs_data === 16'h0000 && bus.rt_data === 16'h0000) else begin
            errors++;
            $error("FAIL rf_cleared: got rs=%h rt=%h expected 0000/0000",
                   bus.rs_data, bus.rt_data);
        end

        // Reset while stalled
        step("lw5", 0, 1, 16'h7280, 8'h25, 0, 0, 3'd0, 16'h0, 0, issued(16'h7280, 8'h25, 0));
        step("rst_stall", 1, 1, 16'h0650, 8'h26, 0, 0, 3'd0, 16'h0, 1, bubble(0));
        step("post_rst2", 0, 1, 16'h0650, 8'h27, 0, 0, 3'd0, 16'h0, 0, issued(16'h0650, 8'h27, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
